// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: forwarding-select and load-use interlock for the
// mips32 five-stage pipeline. Shadows the destination register of the
// instructions in EX, MEM and WB and registers the EX operand mux3 selects
// for the instruction about to enter EX.
module hazard_forward_unit #(
   parameter int REG_BITS = 5,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_uses_rs,
   input  logic                id_uses_rt,
   input  logic [REG_BITS-1:0] id_dest,
   input  logic                id_reg_write,
   input  logic                id_mem_read,
   input  logic                flush,
   output logic                stall,
   output logic                ex_bubble,
   output logic [1:0]          fwd_a,
   output logic [1:0]          fwd_b,
   output logic [CNT_BITS-1:0] stall_count
);

   typedef struct packed {
      logic                valid;
      logic [REG_BITS-1:0] dest;
      logic                reg_write;
      logic                mem_read;
   } entry_t;

   // Index 0 = EX, 1 = MEM, 2 = WB. WB is tracked to mirror the pipeline but
   // never forwarded because the register file writes through.
   entry_t              trk_reg [3];
   logic                ex_bubble_reg;
   logic [1:0]          fwd_reg [2];
   logic [CNT_BITS-1:0] stall_count_reg;

   entry_t              id_entry;
   logic                ex_is_load;
   logic                lu;
   logic                advance;
   logic [REG_BITS-1:0] src [2];
   logic [1:0]          src_used;
   logic [1:0]          fwd_next [2];

   assign id_entry = '{valid: 1'b1, dest: id_dest, reg_write: id_reg_write,
                       mem_read: id_mem_read};

   assign src[0]   = id_rs;
   assign src[1]   = id_rt;
   assign src_used = {id_uses_rt, id_uses_rs};

   // A load in EX whose result is needed by ID cannot be forwarded in time.
   assign ex_is_load = trk_reg[0].valid & trk_reg[0].mem_read &
                       trk_reg[0].reg_write & (trk_reg[0].dest != '0);
   assign lu = id_valid & ex_is_load &
               (((trk_reg[0].dest == id_rs) & id_uses_rs) |
                ((trk_reg[0].dest == id_rt) & id_uses_rt));

   // A flushed consumer is discarded, so there is nothing to stall for.
   assign stall   = lu & ~flush;
   assign advance = id_valid & ~stall & ~flush;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         logic ex_hit;
         logic mem_hit;
         assign ex_hit  = trk_reg[0].valid & trk_reg[0].reg_write &
                          (trk_reg[0].dest == src[gi]) & (src[gi] != '0);
         assign mem_hit = trk_reg[1].valid & trk_reg[1].reg_write &
                          (trk_reg[1].dest == src[gi]) & (src[gi] != '0);
         // Newest producer wins; a load in EX has no ALU result to forward.
         assign fwd_next[gi] = (!advance || !src_used[gi]) ? 2'b00 :
                               (ex_hit && !trk_reg[0].mem_read) ? 2'b01 :
                               mem_hit ? 2'b10 : 2'b00;
      end
   endgenerate

   // Advance the tracking pipeline, register selects and count stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         trk_reg[0]      <= '0;
         trk_reg[1]      <= '0;
         trk_reg[2]      <= '0;
         ex_bubble_reg   <= 1'b1;
         fwd_reg[0]      <= 2'b00;
         fwd_reg[1]      <= 2'b00;
         stall_count_reg <= '0;
      end else begin
         trk_reg[2]    <= trk_reg[1];
         trk_reg[1]    <= trk_reg[0];
         trk_reg[0]    <= advance ? id_entry : '0;
         ex_bubble_reg <= ~advance;
         fwd_reg[0]    <= fwd_next[0];
         fwd_reg[1]    <= fwd_next[1];
         if (stall && (stall_count_reg != '1))
            stall_count_reg <= stall_count_reg + CNT_BITS'(1);
      end
   end

   assign ex_bubble   = ex_bubble_reg;
   assign fwd_a       = fwd_reg[0];
   assign fwd_b       = fwd_reg[1];
   assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: drives instruction sequences into
// the ID-side inputs and checks stall, bubble, forward selects and counters.
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_dest;
   logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
   logic        flush;
   logic        stall, ex_bubble;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_count;
   logic        s_stall, s_ex_bubble;
   logic [1:0]  s_fwd_a, s_fwd_b;
   logic [1:0]  s_stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_forward_unit dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .stall(stall), .ex_bubble(ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_count(stall_count)
   );

   hazard_forward_unit #(.REG_BITS(5), .CNT_BITS(2)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .stall(s_stall), .ex_bubble(s_ex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
      .stall_count(s_stall_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dest,
                         input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_dest = dest; id_reg_write = rw; id_mem_read = mr;
      #1;
   endtask

   task automatic idle(input int n);
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom), 1'($urandom), 1'($urandom));
         tick();
      end
      n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b expected 00", fwd_a); end
      n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b: got %b expected 00", fwd_b); end
      n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble: got %b expected 1", ex_bubble); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
      n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_ex_forward();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$1,$2
      tick();
      set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // sub $4,$3,$5
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL exfwd_stall: got %b expected 0", stall); end
      tick();
      n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL exfwd_a: got %b expected 01", fwd_a); end
      n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL exfwd_b: got %b expected 00", fwd_b); end
      n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL exfwd_bubble: got %b expected 0", ex_bubble); end
      idle(3);
   endtask

   task automatic test_mem_forward();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
      tick();
      idle(1);                                                  // nop
      set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // or $6,$3,$3
      tick();
      n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL memfwd_a: got %b expected 10", fwd_a); end
      n_checks++; if (fwd_b !== 2'b10) begin n_fail++; $display("FAIL memfwd_b: got %b expected 10", fwd_b); end
      idle(3);
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
      tick();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
      tick();
      set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // or $6,$3,$0
      tick();
      n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL newest_a: got %b expected 01", fwd_a); end
      n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL newest_b: got %b expected 00", fwd_b); end
      idle(3);
   endtask

   task automatic test_load_use();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7
      tick();
      set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // add $8,$7,$7
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", stall); end
      tick();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_drop: got %b expected 0", stall); end
      n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b expected 1", ex_bubble); end
      n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_count: got %0d expected 1", stall_count); end
      tick();
      n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_a: got %b expected 10", fwd_a); end
      n_checks++; if (fwd_b !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_b: got %b expected 10", fwd_b); end
      n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_consumer_in_ex: got %b expected 0", ex_bubble); end
      idle(3);
   endtask

   task automatic test_back_to_back();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7,0($1)
      tick();
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7,0($7)
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall1: got %b expected 1", stall); end
      tick();
      tick();
      n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL b2b_lw_fwd_a: got %b expected 10", fwd_a); end
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add $9,$7,$0
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall2: got %b expected 1", stall); end
      tick();
      tick();
      n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL b2b_add_fwd_a: got %b expected 10", fwd_a); end
      n_checks++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", stall_count); end
      idle(3);
   endtask

   task automatic test_flush();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7
      tick();
      set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // dependent add
      flush = 1'b1;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall); end
      tick();
      flush = 1'b0;
      n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble: got %b expected 1", ex_bubble); end
      n_checks++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL flush_count: got %0d expected 3", stall_count); end
      idle(3);
   endtask

   task automatic test_zero_reg();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // add $0
      tick();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // reads $0,$0
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b expected 0", stall); end
      tick();
      n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL zero_fwd_a: got %b expected 00", fwd_a); end
      n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL zero_fwd_b: got %b expected 00", fwd_b); end
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw $0
      tick();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_load_stall: got %b expected 0", stall); end
      idle(3);
   endtask

   task automatic test_reset_mid_stall();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7
      tick();
      set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_stall: got %b expected 1", stall); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b expected 0", stall); end
      n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL midrst_fwd: got %b expected 0000", {fwd_a, fwd_b}); end
      n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", stall_count); end
      idle(3);
   endtask

   task automatic test_saturation();
      for (int n = 1; n <= 5; n++) begin
         set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
         tick();
         set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
         tick();
         tick();
         n_checks++; if (stall_count !== 16'(n)) begin n_fail++; $display("FAIL sat_wide_count%0d: got %0d expected %0d", n, stall_count, n); end
         n_checks++; if (s_stall_count !== ((n > 3) ? 2'd3 : 2'(n))) begin n_fail++; $display("FAIL sat_count%0d: got %0d expected %0d", n, s_stall_count, (n > 3) ? 3 : n); end
         idle(2);
      end
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      test_reset();
      test_ex_forward();
      test_mem_forward();
      test_load_use();
      test_back_to_back();
      test_flush();
      test_zero_reg();
      test_reset_mid_stall();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline-tracking forwarding and load-use interlock unit for the mips32 five-stage core. It shadows the destination register of every instruction in EX, MEM and WB, and drives the 2-bit select codes for the two EX-stage operand `mux3` instances. It also asserts the one-cycle load-use stall and inserts the matching bubble. It sits beside the ID/EX pipeline register and is clocked with it.

## Interface
- `REG_BITS`, default 5: register index width.
- `CNT_BITS`, default 16: stall counter width.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `id_valid` input, 1 bit: the ID stage holds a real instruction.
- `id_rs` input, `REG_BITS`: first source register of the ID instruction.
- `id_rt` input, `REG_BITS`: second source register of the ID instruction.
- `id_uses_rs` input, 1 bit: the ID instruction reads rs.
- `id_uses_rt` input, 1 bit: the ID instruction reads rt.
- `id_dest` input, `REG_BITS`: destination register of the ID instruction, with rd/rt/$31 already resolved.
- `id_reg_write` input, 1 bit: the ID instruction writes `id_dest`.
- `id_mem_read` input, 1 bit: the ID instruction is a load.
- `flush` input, 1 bit: squash the ID instruction (taken branch or jump).
- `stall` output, 1 bit: hold PC and IF/ID. Combinational.
- `ex_bubble` output, 1 bit: EX currently holds a bubble. Registered.
- `fwd_a` output, 2 bits: select for the EX operand-A `mux3`. Registered.
- `fwd_b` output, 2 bits: select for the EX operand-B `mux3`. Registered.
- `stall_count` output, `CNT_BITS`: saturating count of load-use stall cycles. Registered.

## Operation
- Three tracking entries, EX, MEM and WB. Each holds {valid, dest, reg_write, mem_read}.
- An entry "writes r" when valid & reg_write & dest == r & r != 0.
- Select encoding matches the `mux3` inputs:
  - 00: register file (a).
  - 01: EX/MEM ALU result (b).
  - 10: MEM/WB writeback value (c).
  - 11: never driven.
- Load-use condition `lu`: EX entry valid & mem_read & reg_write & dest != 0, and dest == `id_rs` with `id_uses_rs`, or dest == `id_rt` with `id_uses_rt`; also requires `id_valid`.
- `stall = lu & ~flush`. Flush has priority because the dependent instruction is discarded anyway.
- Each rising edge, unless `reset`:
  - WB ← MEM and MEM ← EX, always, including during stall.
  - EX ← ID fields when `id_valid & ~stall & ~flush`. Otherwise EX ← bubble (valid=0), and `ex_bubble` ← 1.
  - `fwd_a` and `fwd_b` are computed for the instruction entering EX, using the pre-edge entries, newest first:
    - EX entry writes the source register and is not a load → 01.
    - Otherwise, MEM entry writes the source register → 10.
    - Otherwise → 00.
    - The 00 case also applies when the corresponding `id_uses_*` is 0 or a bubble is inserted.
  - `stall_count` increments when `stall` is 1, saturating at all-ones.
- WB-stage writes are not forwarded. The register file is write-through in the same cycle.

## Timing
- Reset (synchronous, dominates all other inputs for the cycle):
  - All entries invalid.
  - `fwd_a` = `fwd_b` = 00.
  - `ex_bubble` = 1.
  - `stall_count` = 0.
  - `stall` = 0, since it is derived from the invalid entries.
- Forward selects are valid during the whole cycle in which their instruction occupies EX: latency 1 edge from ID.
- A load-use stall lasts exactly 1 cycle. On the next edge the load is in MEM, the consumer enters EX with select 10, and `stall` drops.
- Back-to-back loads to the same register: each dependent consumer stalls once.
- `flush` together with `lu`: `stall` = 0, a bubble is inserted, and `stall_count` does not increment.
- Reset asserted mid-stall: the next cycle shows `stall` = 0 and all selects 00.
- Writes to $0 never forward and never stall.

## Test plan
- **Reset:** assert `reset` 2 cycles with random ID inputs. Required: `fwd_a`/`fwd_b` = 00, `ex_bubble` = 1, `stall` = 0, `stall_count` = 0.
- **EX→EX forward:** `add $3,..` then `sub $4,$3,$5`. Required: on the sub's EX cycle `fwd_a` = 01 and `fwd_b` = 00.
- **MEM forward and priority:** `add $3`, `nop`, `or $6,$3,$3`. Required: `fwd_a` = `fwd_b` = 10. Then `add $3`, `add $3`, `or $6,$3,$0`. Required: `fwd_a` = 01 (newest wins).
- **Load-use:** `lw $7`, then `add $8,$7,$7`. Required: `stall` = 1 for exactly 1 cycle, `ex_bubble` = 1 the following cycle, the add's EX selects = 10/10, `stall_count` = 1.
- **Flush priority:** `lw $7` with a dependent ID instruction and `flush` = 1 in the same cycle. Required: `stall` = 0, bubble inserted, `stall_count` unchanged.
- **$0 and saturation:**
  - `add $0` followed by a consumer of $0. Required: selects 00, no stall.
  - With `CNT_BITS` = 2, 5 load-use stalls. Required: `stall_count` holds at 3.
